// File: rtl/traffic_light_pkg.sv
// Shared lamp encodings, lamp-state enum and default dwell bounds for the
// traffic-light controller and its monitor.
package traffic_light_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [1:0] {ST_UNK, ST_RED, ST_YEL, ST_GRN} lamp_state_t;

  localparam int GREEN_MIN_DEF  = 4;
  localparam int YELLOW_MIN_DEF = 2;
  localparam int YELLOW_MAX_DEF = 3;
  localparam int STALL_MAX_DEF  = 8;
  localparam int CW_DEF         = 6;

  function automatic lamp_state_t decode_lamp(input logic [2:0] light);
    lamp_state_t s;
    case (light)
      LAMP_RED: s = ST_RED;
      LAMP_YEL: s = ST_YEL;
      LAMP_GRN: s = ST_GRN;
      default:  s = ST_UNK;
    endcase
    return s;
  endfunction

  function automatic lamp_state_t legal_next(input lamp_state_t s);
    lamp_state_t n;
    case (s)
      ST_GRN:  n = ST_YEL;
      ST_YEL:  n = ST_RED;
      ST_RED:  n = ST_GRN;
      default: n = ST_UNK;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tl_lamp_tracker.sv
// One lamp: decode, colour FSM, dwell counter, and the per-lamp
// encoding / sequence / dwell-time checks (single-cycle pulses).
//
// state  | meaning
// UNK    | no trusted colour (after reset or an undecodable sample)
// RED    | lamp showing red
// YEL    | lamp showing yellow
// GRN    | lamp showing green
module tl_lamp_tracker
  import traffic_light_pkg::*;
#(
  parameter int GREEN_MIN  = GREEN_MIN_DEF,
  parameter int YELLOW_MIN = YELLOW_MIN_DEF,
  parameter int YELLOW_MAX = YELLOW_MAX_DEF,
  parameter int CW         = CW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  output logic       red_now,
  output logic       live_now,
  output logic       err_enc,
  output logic       err_seq,
  output logic       err_tim
);

  lamp_state_t   state_q, state_d, dec;
  logic [CW-1:0] dwell_q, dwell_d, dwell_inc;
  logic          exempt_q, exempt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_UNK;
      dwell_q  <= '0;
      exempt_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      exempt_q <= exempt_d;
    end
  end

  // exempt marks an episode entered from UNK: its dwell is never judged
  always_comb begin
    dec       = decode_lamp(light);
    state_d   = state_q;
    dwell_d   = dwell_q;
    exempt_d  = exempt_q;
    err_enc   = 1'b0;
    err_seq   = 1'b0;
    err_tim   = 1'b0;
    dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;
    if (dec == ST_UNK) begin
      err_enc  = 1'b1;
      state_d  = ST_UNK;
      dwell_d  = '0;
      exempt_d = 1'b1;
    end else if (state_q == ST_UNK) begin
      state_d  = dec;
      dwell_d  = CW'(1);
      exempt_d = 1'b1;
    end else if (dec == state_q) begin
      dwell_d = dwell_inc;
      if (state_q == ST_YEL && !exempt_q && dwell_inc == CW'(YELLOW_MAX + 1))
        err_tim = 1'b1;
    end else begin
      state_d  = dec;
      dwell_d  = CW'(1);
      exempt_d = 1'b0;
      err_seq  = (dec != legal_next(state_q));
      if (!exempt_q) begin
        if (state_q == ST_GRN && dwell_q < CW'(GREEN_MIN))  err_tim = 1'b1;
        if (state_q == ST_YEL && dwell_q < CW'(YELLOW_MIN)) err_tim = 1'b1;
      end
    end
  end

  assign red_now  = (dec == ST_RED);
  assign live_now = (dec == ST_YEL) || (dec == ST_GRN);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the traffic-light controller output bus: four lamp
// trackers plus right-of-way conflict, all-red stall, sticky flags, viol_cnt.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int GREEN_MIN  = GREEN_MIN_DEF,
  parameter int YELLOW_MIN = YELLOW_MIN_DEF,
  parameter int YELLOW_MAX = YELLOW_MAX_DEF,
  parameter int STALL_MAX  = STALL_MAX_DEF,
  parameter int CW         = CW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_S,
  input  logic       clr,
  output logic       err_encoding,
  output logic       err_conflict,
  output logic       err_sequence,
  output logic       err_timing,
  output logic       err_stall,
  output logic [7:0] viol_cnt
);

  logic [3:0] red_now, live_now, enc_v, seq_v, tim_v;
  logic [2:0] lights [4];

  assign lights[0] = light_M1;
  assign lights[1] = light_MT;
  assign lights[2] = light_M2;
  assign lights[3] = light_S;

  for (genvar g = 0; g < 4; g++) begin : g_lamp
    tl_lamp_tracker #(
      .GREEN_MIN (GREEN_MIN),
      .YELLOW_MIN(YELLOW_MIN),
      .YELLOW_MAX(YELLOW_MAX),
      .CW        (CW)
    ) u_trk (
      .clk     (clk),
      .rst     (rst),
      .light   (lights[g]),
      .red_now (red_now[g]),
      .live_now(live_now[g]),
      .err_enc (enc_v[g]),
      .err_seq (seq_v[g]),
      .err_tim (tim_v[g])
    );
  end

  logic          fire_enc, fire_con, fire_seq, fire_tim, fire_stall, any_fire;
  logic          all_red;
  logic [CW-1:0] stall_q, stall_inc;

  // index order: 0 M1, 1 MT, 2 M2, 3 S
  assign fire_con  = (live_now[3] && (live_now[0] || live_now[1] || live_now[2])) ||
                     (live_now[1] && live_now[2]);
  assign fire_enc  = |enc_v;
  assign fire_seq  = |seq_v;
  assign fire_tim  = |tim_v;
  assign all_red   = &red_now;
  assign stall_inc = (stall_q == '1) ? stall_q : stall_q + 1'b1;
  // equality (not >) gives one report per stall episode
  assign fire_stall = all_red && (stall_inc == CW'(STALL_MAX + 1));
  assign any_fire   = fire_enc | fire_con | fire_seq | fire_tim | fire_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= all_red ? stall_inc : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_encoding <= 1'b0;
      err_conflict <= 1'b0;
      err_sequence <= 1'b0;
      err_timing   <= 1'b0;
      err_stall    <= 1'b0;
      viol_cnt     <= 8'd0;
    end else if (clr) begin
      err_encoding <= fire_enc;
      err_conflict <= fire_con;
      err_sequence <= fire_seq;
      err_timing   <= fire_tim;
      err_stall    <= fire_stall;
      viol_cnt     <= {7'd0, any_fire};
    end else begin
      err_encoding <= err_encoding | fire_enc;
      err_conflict <= err_conflict | fire_con;
      err_sequence <= err_sequence | fire_seq;
      err_timing   <= err_timing   | fire_tim;
      err_stall    <= err_stall    | fire_stall;
      if (any_fire && viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
    end
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker on the receiving end of the traffic-light controller's output bus. It samples the four lamp groups (main road 1, main-road turn, main road 2, side road) every clock and tracks each lamp through its own red/yellow/green state machine. It flags illegal encodings, conflicting right-of-way, skipped or reversed colour sequences, dwell-time violations and all-red stalls. It sits beside the controller in integration and in benches, and drives no traffic signals itself.

## Interface
- GREEN_MIN, 4: minimum consecutive samples a lamp must stay green.
- YELLOW_MIN, 2: minimum consecutive samples in yellow.
- YELLOW_MAX, 3: maximum consecutive samples in yellow.
- STALL_MAX, 8: maximum consecutive samples with all four lamps red.
- CW, 6: width of the dwell counters. Must hold STALL_MAX+1.

Ports:
- clk  in  1  sampling clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- light_M1  in  3  main road 1 lamp; {red,yellow,green} one-hot.
- light_MT  in  3  main-road turn lamp; same encoding.
- light_M2  in  3  main road 2 lamp; same encoding.
- light_S  in  3  side road lamp; same encoding.
- clr  in  1  synchronous clear of the error flags and the violation count.
- err_encoding  out  1  sticky: a lamp input was not one of 100/010/001.
- err_conflict  out  1  sticky: conflicting lamps were both non-red.
- err_sequence  out  1  sticky: an illegal colour transition occurred.
- err_timing  out  1  sticky: a dwell-time bound was violated.
- err_stall  out  1  sticky: all lamps red for longer than STALL_MAX.
- viol_cnt  out  8  saturating count of cycles that contained at least one new violation.

## Operation
- **Lamp FSM.** There are four identical per-lamp FSMs with states UNK, RED, YEL, GRN. All reset to UNK.
- **Input decode.** 100 → RED, 010 → YEL, 001 → GRN. Any other value forces UNK and raises err_encoding.
- **Legal transitions.** UNK→any legal colour (resync, no sequence check); GRN→YEL; YEL→RED; RED→GRN; any state→itself.
- **Illegal transitions.** GRN→RED, RED→YEL and YEL→GRN raise err_sequence. The FSM still moves to the new colour.
- **Dwell counter.**
  - Each lamp has a CW-bit counter.
  - Set to 1 on the sample where the state changes; incremented on each repeated sample.
  - Saturates at all-ones.
  - The counter is ignored in UNK.
- **Timing checks** (each raises err_timing):
  - GRN left with dwell < GREEN_MIN.
  - YEL left with dwell < YELLOW_MIN.
  - YEL held until dwell would reach YELLOW_MAX+1. This check fires while the lamp is still yellow, once per yellow episode.
  - Dwell bounds are not checked on exit from UNK-entered episodes. The first colour after UNK is exempt.
- **Conflict rule.** err_conflict is raised if either holds in the sampled values:
  - S non-red while any of M1, MT or M2 is non-red;
  - MT non-red while M2 is non-red.
  - Undecodable inputs are excluded from the conflict check.
- **Stall rule.** A separate counter counts consecutive samples with all four lamps RED. err_stall is raised when that count exceeds STALL_MAX, once per stall episode.
- **Flags.** All flags are sticky until clr.
- **viol_cnt.** Increments by 1 in any cycle in which one or more checks fire, regardless of how many fire. Saturates at 255.
- **Clear.** clr clears the flags and viol_cnt. If a check fires in the same cycle as clr, the new violation wins: the relevant flag ends at 1 and viol_cnt at 1.
- **What clr does not touch.** The lamp FSMs and dwell counters are unaffected by clr.

## Timing
- Reset values: all err_* = 0, viol_cnt = 0, all FSMs UNK, all counters 0. Reset takes effect immediately and asynchronously. Checking resumes on the first rising edge after rst deasserts.
- Inputs are sampled on each rising edge; no input registering beyond the FSM state.
- Latency: a violation present at edge k is visible on its flag and on viol_cnt immediately after edge k. There is no further pipeline.
- No handshake; the monitor never back-pressures the controller.
- Reset mid-episode discards all history. The next legal sample resyncs each lamp with no checks.

## Structure
- Shared package traffic_light_pkg holds:
  - the lamp encoding constants RED=3'b100, YEL=3'b010, GRN=3'b001;
  - the lamp-state enum {UNK, RED, YEL, GRN};
  - the default dwell parameters (shared with the controller).
- One sub-module, tl_lamp_tracker: per-lamp decode, FSM, dwell counter, sequence and timing checks. It is instantiated four times.
- The top level holds the conflict logic, the stall counter, the sticky flags and viol_cnt.

## Test plan
- **Legal cycle.** Reset low for 2 cycles. Drive M1/MT GRN×4 → YEL×2 → RED, then M2 GRN×4 → YEL×2, then S GRN×4 → YEL×3. Required: all flags 0 and viol_cnt = 0 throughout.
- **Skipped yellow.** M1 goes from GRN×5 straight to RED. Required: err_sequence = 1 after that edge and viol_cnt = 1. Same test with dwell GRN×2 before the GRN→YEL: err_timing = 1.
- **Long yellow.** Hold M2 yellow for 4 samples. Required: err_timing = 1 on the 4th sample, viol_cnt incremented exactly once.
- **Conflict and encoding.** Drive S=001 with M1=001: err_conflict = 1. Then drive MT=3'b110: err_encoding = 1, MT tracker in UNK, and the next legal MT value raises nothing.
- **Stall and clear.** Hold all lamps red for 9 samples: err_stall = 1 on the 9th. Pulse clr in a clean cycle: flags = 0 and viol_cnt = 0. Pulse clr coincident with a conflict: err_conflict = 1 and viol_cnt = 1.
- **Reset mid-episode and saturation.** Assert rst during yellow: all outputs 0 asynchronously. Then force 300 violating cycles: viol_cnt holds at 255.
